// File: rtl/seg7_readback.sv
// seg7_readback: samples a time-multiplexed, active-low 7-segment bus and
// rebuilds the hex value on each digit. It flags undecodable patterns and
// multi-digit selects, and keeps a saturating error count.
module seg7_readback #(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   dig_en_n,
   input  logic                    err_clr,
   output logic [4*NUM_DIGITS-1:0] hex_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    upd,
   output logic                    err_pattern,
   output logic                    err_sel,
   output logic [7:0]              err_count
);

   localparam int unsigned BusW = NUM_DIGITS + 7;
   localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

   localparam logic [CntW-1:0]       CntMax = CntW'(STABLE_CYCLES);
   localparam logic [CntW-1:0]       CntCap = CntW'(STABLE_CYCLES - 1);
   localparam logic [CntW-1:0]       CntOne = CntW'(1);
   localparam logic [NUM_DIGITS-1:0] SelOne = NUM_DIGITS'(1);
   localparam logic [6:0]            Blank  = 7'h7F;
   localparam logic [7:0]            ErrMax = 8'hFF;

   // Bus sampling: two synchronizer stages (sync2_q is S) plus one delay stage (P)
   logic [BusW-1:0] sync1_q, sync2_q, samp_q;

   // Stability tracking
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            eq;
   logic            capture;

   // Fields of the synchronized sample
   logic [6:0]            seg_s;
   logic [NUM_DIGITS-1:0] sel;
   logic                  sel_none;
   logic                  sel_one;
   logic                  dec_legal;
   logic [3:0]            dec_val;

   // Registered outputs and their next-state values
   logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
   logic [NUM_DIGITS-1:0]   valid_q, valid_d;
   logic                    upd_q, upd_d;
   logic                    errp_q, errp_d;
   logic                    errs_q, errs_d;
   logic [7:0]              errcnt_q, errcnt_d;

   // Returns {legal, value}; legal is 0 for blank and for any unknown pattern
   function automatic logic [4:0] decode(input logic [6:0] p);
      logic [4:0] r;
      r = 5'b0_0000;
      case (p)
         7'b1000000: r = {1'b1, 4'h0};
         7'b1111001: r = {1'b1, 4'h1};
         7'b0100100: r = {1'b1, 4'h2};
         7'b0110000: r = {1'b1, 4'h3};
         7'b0011001: r = {1'b1, 4'h4};
         7'b0010010: r = {1'b1, 4'h5};
         7'b0000010: r = {1'b1, 4'h6};
         7'b1111000: r = {1'b1, 4'h7};
         7'b0000000: r = {1'b1, 4'h8};
         7'b0010000: r = {1'b1, 4'h9};
         7'b0001000: r = {1'b1, 4'hA};
         7'b0000011: r = {1'b1, 4'hB};
         7'b1000110: r = {1'b1, 4'hC};
         7'b0100001: r = {1'b1, 4'hD};
         7'b0000110: r = {1'b1, 4'hE};
         7'b0001110: r = {1'b1, 4'hF};
         default:    r = 5'b0_0000;
      endcase
      return r;
   endfunction

   // Synchronize the bus and keep a one-cycle-old copy; reset to blank / no digit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
         samp_q  <= '1;
      end else begin
         sync1_q <= {dig_en_n, seg_n};
         sync2_q <= sync1_q;
         samp_q  <= sync2_q;
      end
   end

   assign eq      = (sync2_q == samp_q);
   // Counter saturates, so the compare below is true only once per stable period
   assign capture = eq && (cnt_q == CntCap);

   // Stability counter: restart on any change, count up and saturate otherwise
   always_comb begin
      cnt_d = cnt_q;
      if (!eq) begin
         cnt_d = '0;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + CntOne;
      end
   end

   // Stability counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Split the sample into segments and active-high digit selects, then decode
   always_comb begin
      seg_s     = sync2_q[6:0];
      sel       = ~sync2_q[BusW-1:7];
      sel_none  = (sel == '0);
      // Clearing the lowest set bit leaves zero only for a single set bit
      sel_one   = !sel_none && ((sel & (sel - SelOne)) == '0);
      {dec_legal, dec_val} = decode(seg_s);
   end

   // Capture action: update only the selected digit and raise at most one pulse
   always_comb begin
      hex_d   = hex_q;
      valid_d = valid_q;
      upd_d   = 1'b0;
      errp_d  = 1'b0;
      errs_d  = 1'b0;
      if (capture && !sel_none) begin
         if (!sel_one) begin
            errs_d = 1'b1;
         end else if (dec_legal) begin
            upd_d = 1'b1;
         end else if (seg_s != Blank) begin
            errp_d = 1'b1;
         end
      end
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (capture && sel_one && sel[i]) begin
            valid_d[i] = dec_legal;
            if (dec_legal) begin
               hex_d[4*i +: 4] = dec_val;
            end
         end
      end
   end

   // Error counter: clear wins over a same-cycle error, otherwise saturating +1
   always_comb begin
      errcnt_d = errcnt_q;
      if (err_clr) begin
         errcnt_d = '0;
      end else if ((errp_d || errs_d) && (errcnt_q != ErrMax)) begin
         errcnt_d = errcnt_q + 8'd1;
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hex_q    <= '0;
         valid_q  <= '0;
         upd_q    <= 1'b0;
         errp_q   <= 1'b0;
         errs_q   <= 1'b0;
         errcnt_q <= '0;
      end else begin
         hex_q    <= hex_d;
         valid_q  <= valid_d;
         upd_q    <= upd_d;
         errp_q   <= errp_d;
         errs_q   <= errs_d;
         errcnt_q <= errcnt_d;
      end
   end

   assign hex_out     = hex_q;
   assign digit_valid = valid_q;
   assign upd         = upd_q;
   assign err_pattern = errp_q;
   assign err_sel     = errs_q;
   assign err_count   = errcnt_q;

endmodule

// File: tb/tb_seg7_readback.sv
// tb_seg7_readback: directed vectors plus hand-written sequences for latency,
// glitch rejection, error saturation, clear priority and asynchronous reset.
module tb_seg7_readback;

   logic        clk;
   logic        rst_n;
   logic [6:0]  seg_n;
   logic [3:0]  dig_en_n;
   logic        err_clr;
   logic [15:0] hex_out;
   logic [3:0]  digit_valid;
   logic        upd;
   logic        err_pattern;
   logic        err_sel;
   logic [7:0]  err_count;

   seg7_readback #(
      .NUM_DIGITS   (4),
      .STABLE_CYCLES(4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seg_n      (seg_n),
      .dig_en_n   (dig_en_n),
      .err_clr    (err_clr),
      .hex_out    (hex_out),
      .digit_valid(digit_valid),
      .upd        (upd),
      .err_pattern(err_pattern),
      .err_sel    (err_sel),
      .err_count  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [6:0] P2    = 7'b0100100;
   localparam logic [6:0] P3    = 7'b0110000;
   localparam logic [6:0] P5    = 7'b0010010;
   localparam logic [6:0] P7    = 7'b1111000;
   localparam logic [6:0] P8    = 7'b0000000;
   localparam logic [6:0] PA    = 7'b0001000;
   localparam logic [6:0] PD    = 7'b0100001;
   localparam logic [6:0] PF    = 7'b0001110;
   localparam logic [6:0] P1    = 7'b1111001;
   localparam logic [6:0] PBAD  = 7'b1010101;
   localparam logic [6:0] BLANK = 7'b1111111;

   typedef struct {
      logic [3:0]  en;
      logic [6:0]  seg;
      logic [15:0] hex;
      logic [3:0]  valid;
      int          n_upd;
      int          n_errp;
      int          n_errs;
      int          errcnt;
   } vec_t;

   vec_t vecs[10];

   int total = 0;
   int bad   = 0;
   int n_upd, n_errp, n_errs;
   bit seen1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance one rising edge and sample just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_counts();
      n_upd  = 0;
      n_errp = 0;
      n_errs = 0;
      seen1  = 1'b0;
   endtask

   // Run n edges, accumulating pulses and watching digit 2 for a stray '1'
   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         step();
         n_upd  += int'(upd);
         n_errp += int'(err_pattern);
         n_errs += int'(err_sel);
         if (hex_out[11:8] == 4'h1) seen1 = 1'b1;
      end
   endtask

   task automatic drive(input logic [3:0] en, input logic [6:0] seg);
      dig_en_n = en;
      seg_n    = seg;
   endtask

   initial begin
      rst_n    = 1'b0;
      err_clr  = 1'b0;
      seg_n    = BLANK;
      dig_en_n = 4'b1111;

      // Scan digits 0..3, then errors, digit 2 rewrite, blank, and digit 1 again
      vecs[0] = '{4'b1110, P5,    16'h0005, 4'b0001, 1, 0, 0, 0};
      vecs[1] = '{4'b1101, PA,    16'h00A5, 4'b0011, 1, 0, 0, 0};
      vecs[2] = '{4'b1011, PD,    16'h0DA5, 4'b0111, 1, 0, 0, 0};
      vecs[3] = '{4'b0111, PF,    16'hFDA5, 4'b1111, 1, 0, 0, 0};
      vecs[4] = '{4'b1101, PBAD,  16'hFDA5, 4'b1101, 0, 1, 0, 1};
      vecs[5] = '{4'b1100, P3,    16'hFDA5, 4'b1101, 0, 0, 1, 2};
      vecs[6] = '{4'b1111, P8,    16'hFDA5, 4'b1101, 0, 0, 0, 2};
      vecs[7] = '{4'b1011, P7,    16'hF7A5, 4'b1101, 1, 0, 0, 2};
      vecs[8] = '{4'b1011, BLANK, 16'hF7A5, 4'b1001, 0, 0, 0, 2};
      vecs[9] = '{4'b1101, P3,    16'hF735, 4'b1011, 1, 0, 0, 2};

      // Reset state while reset is held
      #12;
      chk("rst_hex", 32'(hex_out), 0);
      chk("rst_valid", 32'(digit_valid), 0);
      chk("rst_pulses", 32'({upd, err_pattern, err_sel}), 0);
      chk("rst_errcnt", 32'(err_count), 0);
      rst_n = 1'b1;
      clr_counts();
      run(8);
      chk("idle_no_pulse", 32'(n_upd + n_errp + n_errs), 0);

      // First capture lands on edge 7 and is never repeated while held
      drive(4'b1110, P2);
      clr_counts();
      run(6);
      chk("lat_no_early_upd", 32'(n_upd), 0);
      chk("lat_hex_before", 32'(hex_out), 0);
      step();
      chk("lat_upd_edge7", 32'(upd), 1);
      chk("lat_hex", 32'(hex_out), 32'h0002);
      chk("lat_valid", 32'(digit_valid), 32'b0001);
      clr_counts();
      run(20);
      chk("held_no_reupd", 32'(n_upd), 0);

      // Table-driven vectors, each held 10 cycles
      for (int v = 0; v < 10; v++) begin
         drive(vecs[v].en, vecs[v].seg);
         clr_counts();
         run(10);
         chk($sformatf("v%0d_hex", v), 32'(hex_out), 32'(vecs[v].hex));
         chk($sformatf("v%0d_valid", v), 32'(digit_valid), 32'(vecs[v].valid));
         chk($sformatf("v%0d_upd", v), 32'(n_upd), 32'(vecs[v].n_upd));
         chk($sformatf("v%0d_errp", v), 32'(n_errp), 32'(vecs[v].n_errp));
         chk($sformatf("v%0d_errs", v), 32'(n_errs), 32'(vecs[v].n_errs));
         chk($sformatf("v%0d_errcnt", v), 32'(err_count), 32'(vecs[v].errcnt));
      end

      // Digit 2 = 7, then short glitches to '1' must not be captured
      drive(4'b1011, P7);
      clr_counts();
      run(10);
      chk("g_setup_valid", 32'(digit_valid), 32'b1111);
      chk("g_setup_upd", 32'(n_upd), 1);
      clr_counts();
      drive(4'b1011, P1);
      run(3);
      drive(4'b1011, P7);
      run(10);
      chk("g3_no_capture", 32'(seen1), 0);
      chk("g3_recapture", 32'(n_upd), 1);
      chk("g3_hex", 32'(hex_out[11:8]), 7);
      clr_counts();
      drive(4'b1011, P1);
      run(4);
      drive(4'b1011, P7);
      run(10);
      chk("g4_no_capture", 32'(seen1), 0);
      clr_counts();
      drive(4'b1011, P1);
      run(5);
      drive(4'b1011, P7);
      run(10);
      chk("g5_captured", 32'(seen1), 1);
      chk("g5_upd_count", 32'(n_upd), 2);
      chk("g5_hex", 32'(hex_out[11:8]), 7);
      clr_counts();
      drive(4'b1011, BLANK);
      run(10);
      chk("blank_valid", 32'(digit_valid), 32'b1011);
      chk("blank_hex", 32'(hex_out), 32'hF735);
      chk("blank_no_pulse", 32'(n_upd + n_errp + n_errs), 0);

      // 300 multi-select errors saturate the counter at 255
      clr_counts();
      for (int i = 0; i < 300; i++) begin
         drive(4'b1100, P8);
         run(6);
         drive(4'b1111, BLANK);
         run(6);
         if (i == 251) chk("sat_254", 32'(err_count), 254);
      end
      chk("sat_errs", 32'(n_errs), 300);
      chk("sat_255", 32'(err_count), 255);
      chk("sat_hex", 32'(hex_out), 32'hF735);
      chk("sat_valid", 32'(digit_valid), 32'b1011);

      // Clear on the same edge as an error wins
      drive(4'b1100, P8);
      run(6);
      err_clr = 1'b1;
      step();
      chk("clr_errsel", 32'(err_sel), 1);
      chk("clr_prio", 32'(err_count), 0);
      err_clr = 1'b0;
      step();
      chk("clr_hold", 32'(err_count), 0);
      drive(4'b1111, BLANK);
      run(6);
      clr_counts();
      drive(4'b1100, P8);
      run(10);
      chk("post_clr_inc", 32'(err_count), 1);
      chk("post_clr_errs", 32'(n_errs), 1);

      // Asynchronous reset between edges, then full latency again
      drive(4'b1110, P5);
      run(3);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_hex", 32'(hex_out), 0);
      chk("arst_valid", 32'(digit_valid), 0);
      chk("arst_errcnt", 32'(err_count), 0);
      step();
      #3;
      rst_n = 1'b1;
      clr_counts();
      run(6);
      chk("arst_no_early", 32'(n_upd), 0);
      step();
      chk("arst_upd_edge7", 32'(upd), 1);
      chk("arst_hex_after", 32'(hex_out), 32'h0005);
      chk("arst_valid_after", 32'(digit_valid), 32'b0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg7_readback.md
Name: seg7_readback

Overview:
- Reader for the board's active-low 7-segment display bus.
- Samples a time-multiplexed segment bus (segments plus digit enables) and reconstructs the 4-bit hex value shown on each digit.
- Flags illegal segment patterns and illegal digit selects, and keeps a saturating error count.
- Used for display self-check and bench readback alongside the segment encoders.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a capture (>=1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- seg_n  input  7  segment lines, active-low; bit0=a ... bit6=g
- dig_en_n  input  NUM_DIGITS  digit enables, active-low; bit i selects digit i
- err_clr  input  1  synchronous clear of err_count
- hex_out  output  4*NUM_DIGITS  decoded values; digit i in bits [4i+3:4i]
- digit_valid  output  NUM_DIGITS  1 = digit i holds a legally decoded value
- upd  output  1  one-cycle pulse on each successful capture
- err_pattern  output  1  one-cycle pulse: captured pattern is neither legal nor blank
- err_sel  output  1  one-cycle pulse: more than one digit enabled at capture
- err_count  output  8  saturating count of err_pattern plus err_sel pulses

Behaviour:
- One clock. Reset is asynchronous and active-low. All state is cleared on rst_n low, immediately and regardless of clock.
- Reset values:
  - hex_out = 0, digit_valid = 0, upd/err_pattern/err_sel = 0, err_count = 0.
  - Stability counter = 0.
  - Sync and sample registers = all ones (blank pattern, no digit enabled).
- Input path:
  - {dig_en_n, seg_n} passes through a 2-flop synchronizer to sample S.
  - P is S delayed one cycle. eq = (S == P).
- Stability counter cnt, width clog2(STABLE_CYCLES+1):
  - If !eq, cnt <= 0.
  - Else cnt increments, saturating at STABLE_CYCLES.
- Capture strobe: eq && cnt == STABLE_CYCLES-1. This fires exactly once per stable period; a held bus never re-captures.
- Latency: pins changed and then held stable → outputs and pulses update on the (STABLE_CYCLES+3)th rising clk edge after the change. With STABLE_CYCLES=4, that is edge 7.
- Glitch rejection: any pin change shorter than STABLE_CYCLES+1 synchronized cycles produces no capture.
- Decode table (seg_n g..a → value):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Action on capture, by number of low bits in dig_en_n:
  - Zero low bits: no update, no pulse.
  - Exactly one low bit (digit i):
    - Pattern in table: hex_out[i] <= value, digit_valid[i] <= 1, upd pulse.
    - Pattern = 1111111 (blank): digit_valid[i] <= 0, hex_out[i] unchanged, no pulse.
    - Any other pattern: digit_valid[i] <= 0, hex_out[i] unchanged, err_pattern pulse.
  - More than one low bit: no digit update, err_sel pulse.
- err_pattern and err_sel are mutually exclusive within a cycle.
- Other digits' hex_out and digit_valid are never disturbed by a capture on digit i.
- err_count:
  - +1 per err_pattern or err_sel pulse; saturates at 255.
  - err_clr sets it to 0. err_clr takes priority over a same-cycle increment.
- Reset mid-operation: every output returns to its reset value at once. After release, the first capture needs the full latency again.
- All outputs are registered.

Test Plan:
- Reset, then hold dig_en_n=1110, seg_n=0100100 → hex_out[3:0]=2, digit_valid=0001, and a single upd pulse on edge 7 (STABLE_CYCLES=4). No further upd while held.
- Scan digits 0..3 with patterns for 5, A, d, F, each held 10 cycles → hex_out=16'hFDA5, digit_valid=1111, 4 upd pulses, err_count=0.
- dig_en_n=1101, seg_n=1010101 → err_pattern pulse, digit_valid[1]=0, hex_out[7:4] unchanged, err_count=1.
- dig_en_n=1100 with a legal pattern → err_sel pulse, no digit changes. 300 such events → err_count=255. Assert err_clr together with an error → err_count=0.
- Digit 2 valid at 7, then bus held 3 cycles with seg_n=1111001 and returned → no capture, hex_out[11:8]=7. Then blank held → digit_valid[2]=0, hex_out[11:8]=7.
- Pull rst_n low asynchronously mid-scan, between clock edges → outputs clear immediately. After release, no upd earlier than edge 7.
